// File: rtl/usb_tx_buffer.sv
// Payload FIFO between the packetizer and an FT245-style USB transmit chip (TXE# / WR handshake).
// Optional packet-granular commit is enabled by defining USB_TX_PKT_COMMIT_EN.
module usb_tx_buffer #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned WR_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8:0]        in_word,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              usb_txe_n,
  output logic [7:0]        usb_data,
  output logic              usb_wr,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_MAX = (WR_PULSE > WR_GAP) ? WR_PULSE : WR_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, GAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               usb_wr_nxt;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, drain_ptr_nxt, used, level_nxt;
  logic               full, push_req, push_ok, reject, pop, start, overflow_nxt;
  logic               txe_meta, txe_sync, txe_ok;

`ifdef USB_TX_PKT_COMMIT_EN
  logic [PTR_W-1:0]   cm_ptr, cm_ptr_nxt;
  logic               drop, drop_nxt, term;
`endif

  // TXE# is asynchronous to clk; flops reset to "not ready"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_meta <= 1'b1;
      txe_sync <= 1'b1;
    end else begin
      txe_meta <= usb_txe_n;
      txe_sync <= txe_meta;
    end
  end

  assign txe_ok = ~txe_sync;

  // Pointer / overflow next-state; full is judged on the pre-cycle occupancy
  always_comb begin
    used         = wr_ptr - rd_ptr;
    full         = (used == PTR_W'(DEPTH));
    push_req     = in_valid & in_word[8];
    pop          = (state == LOAD);
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
    overflow_nxt = overflow;
`ifdef USB_TX_PKT_COMMIT_EN
    term         = in_valid & ~in_word[8];
    cm_ptr_nxt   = cm_ptr;
    drop_nxt     = drop;
    push_ok      = push_req & ~full & ~drop;
    reject       = push_req & full & ~drop;
    if (push_ok) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (reject) begin
      overflow_nxt = 1'b1;
      drop_nxt     = 1'b1;
    end
    // Terminator either publishes the packet or discards a damaged one
    if (term) begin
      if (drop) begin
        wr_ptr_nxt = cm_ptr;
        drop_nxt   = 1'b0;
      end else begin
        cm_ptr_nxt = wr_ptr;
      end
    end
`else
    push_ok      = push_req & ~full;
    reject       = push_req & full;
    if (push_ok) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (reject)  overflow_nxt = 1'b1;
`endif
    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      overflow_nxt = 1'b0;
      push_ok      = 1'b0;
    end
`ifdef USB_TX_PKT_COMMIT_EN
    if (flush) begin
      cm_ptr_nxt = '0;
      drop_nxt   = 1'b0;
    end
    drain_ptr_nxt = cm_ptr_nxt;
`else
    drain_ptr_nxt = wr_ptr_nxt;
`endif
    level_nxt = drain_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      overflow   <= overflow_nxt;
      fifo_level <= level_nxt;
    end
  end

`ifdef USB_TX_PKT_COMMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      cm_ptr <= cm_ptr_nxt;
      drop   <= drop_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= in_word[7:0];
  end

  // Data is latched once per byte and held until the next LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   usb_data <= 8'h00;
    else if (pop) usb_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Drain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      usb_wr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      usb_wr <= usb_wr_nxt;
    end
  end

  // Drain FSM: next state; GAP chains straight into LOAD for back-to-back bytes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = (fifo_level != '0) & txe_ok & ~flush;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_W'(WR_PULSE - 1);
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(WR_GAP - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = start ? LOAD : IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM: outputs, registered from the next state
  always_comb begin
    usb_wr_nxt = (state_nxt == STROBE);
  end

endmodule

// File: tb/tb_usb_tx_buffer.sv
// Randomized self-checking bench for usb_tx_buffer against a queue-based reference model.
// Expectations follow USB_TX_PKT_COMMIT_EN when it is defined for the compile.
module tb_usb_tx_buffer;

  localparam int unsigned DEPTH    = 512;
  localparam int unsigned WR_PULSE = 2;
`ifdef USB_TX_PKT_COMMIT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] in_word;
  logic       in_valid;
  logic       flush;
  logic       usb_txe_n;
  logic [7:0] usb_data;
  logic       usb_wr;
  logic [9:0] fifo_level;
  logic       overflow;

  usb_tx_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .flush      (flush),
    .usb_txe_n  (usb_txe_n),
    .usb_data   (usb_data),
    .usb_wr     (usb_wr),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: committed (drainable) bytes, open-packet bytes, drop and overflow flags
  logic [7:0] exp_q[$];
  logic [7:0] pend[$];
  bit         m_drop;
  bit         m_ovf;

  int         rises = 0;
  int         falls = 0;
  int         hi, lo, max_gap;
  bit         prev_wr, seen_fall;
  logic [7:0] hold;
  bit         lvl_chk = 1'b0;
  bit         rnd_txe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_txe && $urandom_range(9) == 0) usb_txe_n = ~usb_txe_n;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (PKT) begin
      if (!m_drop) begin
        if (exp_q.size() + pend.size() < DEPTH) pend.push_back(b);
        else begin m_drop = 1'b1; m_ovf = 1'b1; end
      end
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_term();
    if (PKT) begin
      if (m_drop) m_drop = 1'b0;
      else foreach (pend[i]) exp_q.push_back(pend[i]);
      pend.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_word  = {1'b1, b};
    in_valid = 1'b1;
    model_push(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_term();
    in_word  = {1'b0, 8'($urandom)};
    in_valid = 1'b1;
    model_term();
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input bit keep_inflight);
    logic [7:0] b;
    flush = 1'b1;
    if (keep_inflight && exp_q.size() > 0) begin
      b = exp_q[0];
      exp_q.delete();
      exp_q.push_back(b);
    end else begin
      exp_q.delete();
    end
    pend.delete();
    m_drop = 1'b0;
    m_ovf  = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || usb_wr || fifo_level != 0) && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(n < limit), 32'd1);
  endtask

  // Bus monitor: each falling usb_wr delivers the next model byte
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr   = 1'b0;
      seen_fall = 1'b0;
      hi        = 0;
      lo        = 0;
    end else begin
      if (usb_wr) begin
        if (!prev_wr) begin
          rises++;
          if (seen_fall) begin
            check("gap_min", 32'(lo >= 3), 32'd1);
            if (lo > max_gap) max_gap = lo;
          end
          hold = usb_data;
          hi   = 1;
        end else begin
          hi++;
          check("data_stable", usb_data, hold);
        end
      end else if (prev_wr) begin
        falls++;
        check("pulse_width", hi, WR_PULSE);
        check("byte_order", usb_data, (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF);
        lo        = 1;
        seen_fall = 1'b1;
      end else begin
        lo++;
      end
      prev_wr = usb_wr;
      if (lvl_chk) check("level_max", 32'(fifo_level <= DEPTH), 32'd1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0, f0;
    rst_n = 1'b0; in_word = '0; in_valid = 1'b0; flush = 1'b0; usb_txe_n = 1'b1;
    m_drop = 1'b0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", usb_wr, 0);
    check("rst_data", usb_data, 8'h00);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    usb_txe_n = 1'b0;
    repeat (3) step();

    // Reset asserted while a byte is being strobed
    send_byte(8'hA5);
    send_term();
    n = 0;
    while (!usb_wr && n < 20) begin step(); n++; end
    check("rst_strobe_seen", usb_wr, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_wr", usb_wr, 0);
    exp_q.delete(); pend.delete(); m_drop = 1'b0; m_ovf = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rel_data", usb_data, 8'h00);
    check("rel_level", fifo_level, 0);
    check("rel_ovf", overflow, 0);
    check("rel_wr", usb_wr, 0);

    // Basic drain and push-to-strobe latency (txe already synchronised)
    repeat (3) step();
    seen_fall = 1'b0; max_gap = 0; r0 = rises;
    send_byte(8'h01); check("lat_edge0", usb_wr, 0);
    send_byte(8'h02); check("lat_edge1", usb_wr, 0);
    send_byte(8'h03); check("lat_edge2", usb_wr, PKT ? 0 : 1);
    send_term();
    wait_drain(100, "basic_drain");
    check("basic_pulses", rises - r0, 3);
    check("basic_gap", max_gap, 3);

    // Backpressure, then release: sync (2 edges) + LOAD + strobe edge
    usb_txe_n = 1'b1;
    repeat (3) step();
    r0 = rises;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    send_term();
    repeat (4) step();
    check("bp_no_wr", rises - r0, 0);
    check("bp_level", fifo_level, 10);
    usb_txe_n = 1'b0;
    n = 0;
    do begin step(); n++; end while (!usb_wr && n < 20);
    check("txe_latency", n, 4);
    wait_drain(200, "bp_drain");

    // Overflow with drain stalled, then flush
    usb_txe_n = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 512; i++) send_byte(8'($urandom));
    check("ovf_pre", overflow, m_ovf);
    check("level_full", fifo_level, PKT ? 0 : 512);
    send_byte(8'($urandom));
    check("ovf_set", overflow, 1);
    check("level_513", fifo_level, PKT ? 0 : 512);
    send_term();
    check("level_term", fifo_level, exp_q.size());
    do_flush(1'b0);
    check("flush_level", fifo_level, 0);
    check("flush_ovf", overflow, 0);

    // Two 300-byte packets: the second cannot fit
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 300; i++) send_byte(8'($urandom));
      send_term();
    end
    check("pkt_level", fifo_level, PKT ? 300 : 512);
    check("pkt_ovf", overflow, 1);
    f0 = falls;
    usb_txe_n = 1'b0;
    wait_drain(4000, "pkt_drain");
    check("pkt_bytes", falls - f0, PKT ? 300 : 512);

    // Flush while a byte is on the bus: that byte still completes
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    send_term();
    n = 0;
    while (!usb_wr && n < 40) begin step(); n++; end
    check("fl_strobe_seen", usb_wr, 1);
    do_flush(1'b1);
    f0 = falls;
    check("fl_level", fifo_level, 0);
    wait_drain(100, "fl_drain");
    check("fl_bytes", falls - f0, 1);

    // Wrap: 3 rounds of 400 bytes with random gaps, terminators and TXE#
    for (int r = 0; r < 3; r++) begin
      lvl_chk = 1'b1;
      rnd_txe = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(3) == 0) step();
        send_byte(8'($urandom));
        if ($urandom_range(9) == 0) send_term();
      end
      send_term();
      rnd_txe = 1'b0;
      usb_txe_n = 1'b0;
      wait_drain(3000, "wrap_drain");
      check("wrap_level", fifo_level, 0);
      check("wrap_ovf", overflow, 0);
    end
    lvl_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
